// File: rtl/decode_queue.sv
// Instruction queue with decode, operand resolve, CDB snoop and a
// dispatch register; JALR with a pending base stalls until resolved.
// Ports: in_* enqueue; rj/rk and vj/vk/qj/qk talk to the register
// file; cdb_* result broadcasts; disp_* dispatch handshake and
// fields; redirect_* JALR target back to fetch.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int N_CDB = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_ins,
  input  logic                   in_jp,
  output logic                   in_ready,
  output logic [4:0]             rj,
  output logic [4:0]             rk,
  input  logic [31:0]            vj,
  input  logic [31:0]            vk,
  input  logic [TAG_W:0]         qj,
  input  logic [TAG_W:0]         qk,
  input  logic [N_CDB-1:0]       cdb_ok,
  input  logic [N_CDB*TAG_W-1:0] cdb_tag,
  input  logic [N_CDB*32-1:0]    cdb_val,
  input  logic [TAG_W-1:0]       disp_tag,
  output logic                   disp_valid,
  input  logic                   disp_ready,
  output logic [1:0]             disp_unit,
  output logic [5:0]             disp_opt,
  output logic [4:0]             disp_rd,
  output logic [31:0]            disp_vj,
  output logic [31:0]            disp_vk,
  output logic [TAG_W:0]         disp_qj,
  output logic [TAG_W:0]         disp_qk,
  output logic [31:0]            disp_imm,
  output logic [31:0]            disp_pc,
  output logic                   disp_jp,
  output logic [31:0]            disp_rob_val,
  output logic                   disp_rob_isok,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc
);
  localparam int TQ = TAG_W + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TQ-1:0] NO_DEP = {1'b1, {TAG_W{1'b0}}};

  typedef enum logic [3:0] {
    K_BAD, K_LUI, K_AUIPC, K_JAL, K_JALR,
    K_R, K_I, K_BR, K_LD, K_ST
  } kind_t;
  typedef enum logic {S_NORM, S_WAIT} st_t;

  function automatic logic [TQ+31:0] snoop(
    input logic [31:0]            v,
    input logic [TQ-1:0]          q,
    input logic [N_CDB-1:0]       ok,
    input logic [N_CDB*TAG_W-1:0] tg,
    input logic [N_CDB*32-1:0]    vl
  );
    logic [31:0]   rv;
    logic [TQ-1:0] rq;
    rv = v;
    rq = q;
    for (int c = 0; c < N_CDB; c++)
      if (!q[TAG_W] && ok[c] &&
          tg[c*TAG_W +: TAG_W] == q[TAG_W-1:0]) begin
        rv = vl[c*32 +: 32];
        rq = NO_DEP;
      end
    return {rq, rv};
  endfunction

  // rename bypass beats CDB beats register file; x0 never waits
  function automatic logic [TQ+31:0] resolve(
    input logic [4:0]             rs,
    input logic [31:0]            v,
    input logic [TQ-1:0]          q,
    input logic                   byp,
    input logic [TAG_W-1:0]       bt,
    input logic [N_CDB-1:0]       ok,
    input logic [N_CDB*TAG_W-1:0] tg,
    input logic [N_CDB*32-1:0]    vl
  );
    logic [TQ+31:0] r;
    r = snoop(v, q, ok, tg, vl);
    if (byp) r = {1'b0, bt, 32'd0};
    if (rs == 5'd0) r = {NO_DEP, 32'd0};
    return r;
  endfunction

  logic [31:0] m_pc  [DEPTH];
  logic [31:0] m_ins [DEPTH];
  logic        m_jp  [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  st_t st, st_n;
  logic [31:0]   jw_v;
  logic [TQ-1:0] jw_q;

  logic [31:0] h_ins, h_pc;
  logic        h_jp, empty, enq, deq, fire;
  assign h_ins = m_ins[head];
  assign h_pc  = m_pc[head];
  assign h_jp  = m_jp[head];
  assign empty = count == '0;
  assign in_ready = count < CW'(DEPTH);
  assign enq  = in_valid && in_ready;
  assign fire = disp_valid && disp_ready;

  kind_t       k;
  logic [5:0]  opt;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic [2:0]  f3;
  logic        f7b;
  assign f3  = h_ins[14:12];
  assign f7b = h_ins[30];
  assign imm_i  = {{20{h_ins[31]}}, h_ins[31:20]};
  assign imm_s  = {{20{h_ins[31]}}, h_ins[31:25], h_ins[11:7]};
  assign imm_b  = {{19{h_ins[31]}}, h_ins[31], h_ins[7],
                   h_ins[30:25], h_ins[11:8], 1'b0};
  assign imm_u  = {h_ins[31:12], 12'd0};
  assign imm_j  = {{11{h_ins[31]}}, h_ins[31], h_ins[19:12],
                   h_ins[20], h_ins[30:21], 1'b0};
  assign imm_sh = {27'd0, h_ins[24:20]};

  always_comb begin
    k     = K_BAD;
    opt   = '0;
    d_rd  = h_ins[11:7];
    d_rs1 = h_ins[19:15];
    d_rs2 = '0;
    imm   = '0;
    case (h_ins[6:0])
      7'b0110111: begin
        k = K_LUI; opt = 6'o00; d_rs1 = '0; imm = imm_u;
      end
      7'b0010111: begin k = K_AUIPC; opt = 6'o01; imm = imm_u; end
      7'b1101111: begin k = K_JAL; opt = 6'o02; imm = imm_j; end
      7'b1100111: begin k = K_JALR; opt = 6'o37; imm = imm_i; end
      7'b1100011: begin
        k = K_BR; opt = {3'o4, f3}; d_rd = '0;
        d_rs2 = h_ins[24:20]; imm = imm_b;
      end
      7'b0000011: begin k = K_LD; opt = {3'o5, f3}; imm = imm_i; end
      7'b0100011: begin
        k = K_ST; opt = {3'o7, f3}; d_rd = '0;
        d_rs2 = h_ins[24:20]; imm = imm_s;
      end
      7'b0010011: begin
        k = K_I; imm = imm_i;
        case (f3)
          3'd0: opt = 6'o20;
          3'd2: opt = 6'o21;
          3'd3: opt = 6'o22;
          3'd4: opt = 6'o23;
          3'd6: opt = 6'o24;
          3'd7: opt = 6'o25;
          3'd1: begin opt = 6'o26; imm = imm_sh; end
          default: begin
            opt = f7b ? 6'o30 : 6'o27; imm = imm_sh;
          end
        endcase
      end
      7'b0110011: begin
        k = K_R; d_rs2 = h_ins[24:20];
        case (f3)
          3'd0: opt = f7b ? 6'o04 : 6'o03;
          3'd1: opt = 6'o05;
          3'd2: opt = 6'o06;
          3'd3: opt = 6'o07;
          3'd4: opt = 6'o10;
          3'd5: opt = f7b ? 6'o12 : 6'o11;
          3'd6: opt = 6'o13;
          default: opt = 6'o14;
        endcase
      end
      default: ;
    endcase
  end

  assign rj = empty ? 5'd0 : d_rs1;
  assign rk = empty ? 5'd0 : d_rs2;

  logic [31:0]   rv_j, rv_k, wv, oj_v, sv_j, sv_k;
  logic [TQ-1:0] rq_j, rq_k, wq, oj_q, sq_j, sq_k;
  assign {rq_j, rv_j} = resolve(d_rs1, vj, qj,
    fire && disp_rd != 5'd0 && disp_rd == d_rs1,
    disp_tag, cdb_ok, cdb_tag, cdb_val);
  assign {rq_k, rv_k} = resolve(d_rs2, vk, qk,
    fire && disp_rd != 5'd0 && disp_rd == d_rs2,
    disp_tag, cdb_ok, cdb_tag, cdb_val);
  assign {wq, wv} = snoop(jw_v, jw_q, cdb_ok, cdb_tag, cdb_val);
  assign {sq_j, sv_j} = snoop(disp_vj, disp_qj,
    cdb_ok, cdb_tag, cdb_val);
  assign {sq_k, sv_k} = snoop(disp_vk, disp_qk,
    cdb_ok, cdb_tag, cdb_val);

  // a waiting JALR takes its base from the snooped wait copy
  assign oj_v = (st == S_WAIT) ? wv : rv_j;
  assign oj_q = (st == S_WAIT) ? wq : rq_j;

  logic j_rdy, slot_free, hv, load, go_wait;
  assign j_rdy     = oj_q == NO_DEP;
  assign slot_free = !disp_valid || disp_ready;
  assign hv        = !empty && k != K_BAD;
  assign load      = hv && slot_free && (k != K_JALR || j_rdy);
  assign go_wait   = st == S_NORM && hv && slot_free &&
                     k == K_JALR && !j_rdy;
  assign deq       = load || (!empty && k == K_BAD);

  always_comb begin
    st_n = st;
    case (st)
      S_NORM: if (go_wait) st_n = S_WAIT;
      S_WAIT: if (load) st_n = S_NORM;
      default: st_n = S_NORM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) st <= S_NORM;
    else if (rdy)     st <= st_n;
  end

  logic [1:0]    o_unit;
  logic [31:0]   o_vj, o_vk, o_imm, o_rv;
  logic [TQ-1:0] o_qk;
  logic          o_ok;
  always_comb begin
    o_unit = 2'd2;
    o_vj   = oj_v;
    o_vk   = rv_k;
    o_qk   = rq_k;
    o_imm  = imm;
    o_rv   = '0;
    o_ok   = 1'b0;
    unique case (1'b1)
      k == K_LD: begin
        o_unit = 2'd1; o_vk = imm; o_qk = NO_DEP;
      end
      k == K_ST: begin
        o_unit = 2'd1; o_vj = j_rdy ? oj_v + imm : 32'd0;
      end
      k == K_I: begin
        o_unit = 2'd0; o_vk = imm; o_qk = NO_DEP;
      end
      k == K_R: o_unit = 2'd0;
      k == K_BR: begin
        o_unit = 2'd0;
        o_imm  = h_jp ? h_pc + 32'd4 : h_pc + imm;
      end
      k == K_LUI:   begin o_rv = imm; o_ok = 1'b1; end
      k == K_AUIPC: begin o_rv = h_pc + imm; o_ok = 1'b1; end
      k == K_JAL || k == K_JALR: begin
        o_rv = h_pc + 32'd4; o_ok = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && rdy && enq) begin
      m_pc[tail]  <= in_pc;
      m_ins[tail] <= in_ins;
      m_jp[tail]  <= in_jp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      jw_v  <= '0;
      jw_q  <= NO_DEP;
    end else if (rdy) begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (go_wait) begin
        jw_v <= rv_j;
        jw_q <= rq_j;
      end else if (st == S_WAIT) begin
        jw_v <= wv;
        jw_q <= wq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_valid     <= 1'b0;
      disp_unit      <= '0;
      disp_opt       <= '0;
      disp_rd        <= '0;
      disp_vj        <= '0;
      disp_vk        <= '0;
      disp_qj        <= NO_DEP;
      disp_qk        <= NO_DEP;
      disp_imm       <= '0;
      disp_pc        <= '0;
      disp_jp        <= 1'b0;
      disp_rob_val   <= '0;
      disp_rob_isok  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (clear) begin
      disp_valid     <= 1'b0;
      redirect_valid <= 1'b0;
    end else if (rdy) begin
      redirect_valid <= 1'b0;
      if (load) begin
        disp_valid    <= 1'b1;
        disp_unit     <= o_unit;
        disp_opt      <= opt;
        disp_rd       <= d_rd;
        disp_vj       <= o_vj;
        disp_vk       <= o_vk;
        disp_qj       <= oj_q;
        disp_qk       <= o_qk;
        disp_imm      <= o_imm;
        disp_pc       <= h_pc;
        disp_jp       <= h_jp;
        disp_rob_val  <= o_rv;
        disp_rob_isok <= o_ok;
        if (k == K_JALR) begin
          redirect_valid <= 1'b1;
          redirect_pc    <= (oj_v + imm) & ~32'd1;
        end
      end else if (disp_valid && !disp_ready) begin
        // a store's base becomes base+offset once it arrives
        if (disp_opt[5:3] == 3'o7 && !disp_qj[TAG_W] &&
            sq_j == NO_DEP)
          disp_vj <= sv_j + disp_imm;
        else
          disp_vj <= sv_j;
        disp_qj <= sq_j;
        disp_vk <= sv_k;
        disp_qk <= sq_k;
      end else begin
        disp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: one task per scenario with
// inline checks against hand-computed values.
module tb_decode_queue;
  localparam logic [4:0] NO_DEP = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_ins = '0;
  logic        in_jp = 1'b0;
  logic        in_ready;
  logic [4:0]  rj, rk;
  logic [31:0] vj, vk;
  logic [4:0]  qj, qk;
  logic [1:0]  cdb_ok = '0;
  logic [7:0]  cdb_tag = '0;
  logic [63:0] cdb_val = '0;
  logic [3:0]  disp_tag = 4'd5;
  logic        disp_valid;
  logic        disp_ready = 1'b0;
  logic [1:0]  disp_unit;
  logic [5:0]  disp_opt;
  logic [4:0]  disp_rd;
  logic [31:0] disp_vj, disp_vk;
  logic [4:0]  disp_qj, disp_qk;
  logic [31:0] disp_imm, disp_pc;
  logic        disp_jp;
  logic [31:0] disp_rob_val;
  logic        disp_rob_isok;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] regv [32];
  logic [4:0]  regq [32];
  assign vj = regv[rj];
  assign vk = regv[rk];
  assign qj = regq[rj];
  assign qk = regq[rk];

  decode_queue #(.DEPTH(4), .TAG_W(4), .N_CDB(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .in_valid(in_valid), .in_pc(in_pc), .in_ins(in_ins),
    .in_jp(in_jp), .in_ready(in_ready), .rj(rj), .rk(rk),
    .vj(vj), .vk(vk), .qj(qj), .qk(qk),
    .cdb_ok(cdb_ok), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .disp_tag(disp_tag), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .disp_unit(disp_unit),
    .disp_opt(disp_opt), .disp_rd(disp_rd),
    .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_jp(disp_jp), .disp_rob_val(disp_rob_val),
    .disp_rob_isok(disp_rob_isok),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd,
                                       input logic [11:0] im);
    return {im, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_in_ready got %0h exp 1", in_ready);
    end
    nvec++;
    if (disp_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_valid got %0h/%0h exp 0/0",
               disp_valid, redirect_valid);
    end
    nvec++;
    if (disp_qj !== NO_DEP || disp_qk !== NO_DEP) begin
      nerr++;
      $display("FAIL rst_q got %0h/%0h exp 10/10", disp_qj, disp_qk);
    end
    nvec++;
    if (disp_vj !== 32'd0 || disp_rob_val !== 32'd0 || rj !== 5'd0)
    begin
      nerr++;
      $display("FAIL rst_zero got vj %0h rob %0h rj %0h exp 0",
               disp_vj, disp_rob_val, rj);
    end
  endtask

  task automatic test_addi;
    disp_ready = 1'b1;
    in_pc = 32'h100;
    in_ins = 32'h00500093;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    nvec++;
    if (disp_valid !== 1'b0) begin
      nerr++; $display("FAIL addi_early got %0h exp 0", disp_valid);
    end
    tick();
    nvec++;
    if (disp_valid !== 1'b1 || disp_unit !== 2'd0 || disp_rd !== 5'd1)
    begin
      nerr++;
      $display("FAIL addi_disp got v%0h u%0h rd%0h exp v1 u0 rd1",
               disp_valid, disp_unit, disp_rd);
    end
    nvec++;
    if (disp_vk !== 32'd5 || disp_qj !== NO_DEP || disp_qk !== NO_DEP
        || disp_opt !== 6'o20) begin
      nerr++;
      $display("FAIL addi_ops got vk%0h qj%0h qk%0h op%0h exp 5 10 10 10",
               disp_vk, disp_qj, disp_qk, disp_opt);
    end
    tick();
    nvec++;
    if (disp_valid !== 1'b0) begin
      nerr++; $display("FAIL addi_drain got %0h exp 0", disp_valid);
    end
  endtask

  task automatic test_fill;
    disp_ready = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      in_ins = addi(5'(n), 12'(n));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    nvec++;
    if (in_ready !== 1'b0 || disp_rd !== 5'd1) begin
      nerr++;
      $display("FAIL fill_full got rdy%0h rd%0h exp 0 1",
               in_ready, disp_rd);
    end
    rdy = 1'b0;
    disp_ready = 1'b1;
    tick();
    nvec++;
    if (disp_rd !== 5'd1 || in_ready !== 1'b0 || disp_valid !== 1'b1)
    begin
      nerr++;
      $display("FAIL fill_freeze got rd%0h rdy%0h v%0h exp 1 0 1",
               disp_rd, in_ready, disp_valid);
    end
    rdy = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      nvec++;
      if (disp_valid !== 1'b1 || disp_rd !== 5'(n) ||
          disp_vk !== 32'(n)) begin
        nerr++;
        $display("FAIL fill_order got v%0h rd%0h vk%0h exp 1 %0h %0h",
                 disp_valid, disp_rd, disp_vk, n, n);
      end
      tick();
    end
    nvec++;
    if (disp_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL fill_empty got v%0h rdy%0h exp 0 1",
               disp_valid, in_ready);
    end
  endtask

  task automatic test_cdb_stall;
    regq[1] = 5'h03;
    regv[1] = 32'd0;
    disp_ready = 1'b0;
    in_ins = 32'h00108133;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    nvec++;
    if (disp_valid !== 1'b1 || disp_qj !== 5'h03 || disp_qk !== 5'h03)
    begin
      nerr++;
      $display("FAIL cdb_pre got v%0h qj%0h qk%0h exp 1 3 3",
               disp_valid, disp_qj, disp_qk);
    end
    cdb_ok = 2'b01;
    cdb_tag = {4'd0, 4'd3};
    cdb_val = {32'd0, 32'h10};
    tick();
    cdb_ok = 2'b00;
    nvec++;
    if (disp_qj !== NO_DEP || disp_qk !== NO_DEP ||
        disp_vj !== 32'h10 || disp_vk !== 32'h10 ||
        disp_valid !== 1'b1) begin
      nerr++;
      $display("FAIL cdb_snoop got qj%0h qk%0h vj%0h vk%0h v%0h",
               disp_qj, disp_qk, disp_vj, disp_vk, disp_valid);
    end
    disp_ready = 1'b1;
    tick();
    regq[1] = NO_DEP;
    regv[1] = 32'h1000;
  endtask

  task automatic test_jalr;
    regq[5] = 5'h02;
    disp_ready = 1'b1;
    in_pc = 32'h200;
    in_ins = 32'h008280E7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    nvec++;
    if (disp_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      nerr++;
      $display("FAIL jalr_wait got v%0h rv%0h exp 0 0",
               disp_valid, redirect_valid);
    end
    cdb_ok = 2'b10;
    cdb_tag = {4'd2, 4'd0};
    cdb_val = {32'h100, 32'h0};
    tick();
    cdb_ok = 2'b00;
    nvec++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h108) begin
      nerr++;
      $display("FAIL jalr_redir got v%0h pc%0h exp 1 108",
               redirect_valid, redirect_pc);
    end
    nvec++;
    if (disp_valid !== 1'b1 || disp_unit !== 2'd2 ||
        disp_rob_val !== 32'h204 || disp_rob_isok !== 1'b1 ||
        disp_vj !== 32'h100) begin
      nerr++;
      $display("FAIL jalr_disp got v%0h u%0h rob%0h ok%0h vj%0h",
               disp_valid, disp_unit, disp_rob_val, disp_rob_isok,
               disp_vj);
    end
    tick();
    nvec++;
    if (redirect_valid !== 1'b0 || disp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL jalr_pulse got rv%0h v%0h exp 0 0",
               redirect_valid, disp_valid);
    end
    regq[5] = NO_DEP;
  endtask

  task automatic test_back_to_back;
    disp_ready = 1'b1;
    in_ins = addi(5'd3, 12'd7);
    in_valid = 1'b1;
    tick();
    in_ins = 32'h00018233;
    tick();
    in_valid = 1'b0;
    nvec++;
    if (disp_valid !== 1'b1 || disp_rd !== 5'd3) begin
      nerr++;
      $display("FAIL b2b_first got v%0h rd%0h exp 1 3",
               disp_valid, disp_rd);
    end
    tick();
    nvec++;
    if (disp_rd !== 5'd4 || disp_qj !== 5'h05 ||
        disp_qk !== NO_DEP || disp_vj !== 32'd0) begin
      nerr++;
      $display("FAIL b2b_bypass got rd%0h qj%0h qk%0h vj%0h",
               disp_rd, disp_qj, disp_qk, disp_vj);
    end
    tick();
  endtask

  task automatic test_fields;
    disp_ready = 1'b1;
    in_pc = 32'h400; in_jp = 1'b0; in_ins = 32'h0020A223;
    in_valid = 1'b1;
    tick();
    in_pc = 32'h300; in_jp = 1'b1; in_ins = 32'h00208863;
    tick();
    nvec++;
    if (disp_unit !== 2'd1 || disp_vj !== 32'h1004 ||
        disp_vk !== 32'h2000 || disp_rd !== 5'd0 ||
        disp_opt !== 6'o72) begin
      nerr++;
      $display("FAIL sw got u%0h vj%0h vk%0h rd%0h op%0h",
               disp_unit, disp_vj, disp_vk, disp_rd, disp_opt);
    end
    in_pc = 32'h500; in_jp = 1'b0; in_ins = 32'h123453B7;
    tick();
    in_valid = 1'b0;
    nvec++;
    if (disp_unit !== 2'd0 || disp_imm !== 32'h304 ||
        disp_rd !== 5'd0 || disp_opt !== 6'o40 || disp_jp !== 1'b1)
    begin
      nerr++;
      $display("FAIL beq got u%0h imm%0h rd%0h op%0h jp%0h",
               disp_unit, disp_imm, disp_rd, disp_opt, disp_jp);
    end
    tick();
    nvec++;
    if (disp_unit !== 2'd2 || disp_rob_val !== 32'h12345000 ||
        disp_rob_isok !== 1'b1 || disp_qj !== NO_DEP) begin
      nerr++;
      $display("FAIL lui got u%0h rob%0h ok%0h qj%0h",
               disp_unit, disp_rob_val, disp_rob_isok, disp_qj);
    end
    tick();
  endtask

  task automatic test_unsupported;
    disp_ready = 1'b1;
    in_ins = 32'h0000007F;
    in_valid = 1'b1;
    tick();
    in_ins = addi(5'd6, 12'd6);
    tick();
    in_valid = 1'b0;
    nvec++;
    if (disp_valid !== 1'b0) begin
      nerr++; $display("FAIL bad_drop got %0h exp 0", disp_valid);
    end
    tick();
    nvec++;
    if (disp_valid !== 1'b1 || disp_rd !== 5'd6 || disp_vk !== 32'd6)
    begin
      nerr++;
      $display("FAIL bad_next got v%0h rd%0h vk%0h exp 1 6 6",
               disp_valid, disp_rd, disp_vk);
    end
    tick();
  endtask

  task automatic test_clear;
    disp_ready = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      in_ins = addi(5'(n + 8), 12'(n));
      in_valid = 1'b1;
      tick();
    end
    in_ins = addi(5'd13, 12'd13);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    nvec++;
    if (disp_valid !== 1'b0 || in_ready !== 1'b1 || rj !== 5'd0) begin
      nerr++;
      $display("FAIL clr_now got v%0h rdy%0h rj%0h exp 0 1 0",
               disp_valid, in_ready, rj);
    end
    disp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      nvec++;
      if (disp_valid !== 1'b0) begin
        nerr++; $display("FAIL clr_after got %0h exp 0", disp_valid);
      end
    end
  endtask

  task automatic test_reset_jalr;
    regq[5] = 5'h02;
    disp_ready = 1'b1;
    in_pc = 32'h600;
    in_ins = 32'h008280E7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    cdb_ok = 2'b10;
    cdb_tag = {4'd2, 4'd0};
    cdb_val = {32'h100, 32'h0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cdb_ok = 2'b00;
    regq[5] = NO_DEP;
    nvec++;
    if (redirect_valid !== 1'b0 || disp_valid !== 1'b0 ||
        in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rstj_now got rv%0h v%0h rdy%0h exp 0 0 1",
               redirect_valid, disp_valid, in_ready);
    end
    tick();
    nvec++;
    if (redirect_valid !== 1'b0 || disp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rstj_later got rv%0h v%0h exp 0 0",
               redirect_valid, disp_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      regv[i] = 32'(i) << 12;
      regq[i] = NO_DEP;
    end
    test_reset();
    test_addi();
    test_fill();
    test_cdb_stall();
    test_jalr();
    test_back_to_back();
    test_fields();
    test_unsupported();
    test_clear();
    test_reset_jalr();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
